// File: rtl/fetch_queue_stage_if.sv
// rtl/fetch_queue_stage_if.sv - memory read, redirect and decoder-side signals of the fetch queue stage
interface fetch_queue_stage_if #(
   parameter int MEM_WIDTH = 64
);
   logic                 mem_ren;
   logic [63:0]          mem_raddr;
   logic                 mem_rvalid;
   logic [MEM_WIDTH-1:0] mem_rdata;
   logic                 set_pc_valid;
   logic [63:0]          set_pc;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_instr;
   logic [63:0]          out_pc;

   modport master (
      output mem_ren, mem_raddr, out_valid, out_instr, out_pc,
      input  mem_rvalid, mem_rdata, set_pc_valid, set_pc, out_ready
   );

   modport slave (
      input  mem_ren, mem_raddr, out_valid, out_instr, out_pc,
      output mem_rvalid, mem_rdata, set_pc_valid, set_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - beat fetch with outstanding reads, lane split and instruction queue
module fetch_queue_stage #(
   parameter int          MEM_WIDTH    = 64,
   parameter int          QUEUE_DEPTH  = 8,
   parameter int          MAX_INFLIGHT = 2,
   parameter logic [63:0] RESET_PC     = 64'h0
) (
   input logic                 clk,
   input logic                 rst,
   fetch_queue_stage_if.master bus
);
   localparam int IPB        = MEM_WIDTH / 32;
   localparam int BEAT_BYTES = MEM_WIDTH / 8;
   localparam int QW         = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW         = $clog2(QUEUE_DEPTH + 1);
   localparam int IW         = $clog2(MAX_INFLIGHT + 1);
   localparam int RW         = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int LW         = (IPB > 1) ? $clog2(IPB) : 1;
   localparam logic [63:0] BEAT_MASK = ~(64'(BEAT_BYTES) - 64'd1);

   logic [63:0]   fetch_pc;
   logic [31:0]   q_instr [QUEUE_DEPTH];
   logic [63:0]   q_pc    [QUEUE_DEPTH];
   logic [QW-1:0] wr_ptr;
   logic [QW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [63:0]   ri_addr [MAX_INFLIGHT];
   logic [LW-1:0] ri_lane [MAX_INFLIGHT];
   logic [RW-1:0] ri_wr;
   logic [RW-1:0] ri_rd;
   logic [IW-1:0] inflight;
   logic [IW-1:0] discard;

   logic [63:0]   beat_addr;
   logic [LW-1:0] start_lane;
   logic          issue;
   logic          resp;
   logic          accept;
   logic          deq;
   logic [63:0]   resp_addr;
   logic [LW-1:0] resp_lane;
   logic [CW-1:0] n_enq;
   logic [CW-1:0] remaining;
   logic [31:0]   enq_instr [IPB];
   logic [63:0]   enq_pc    [IPB];
   logic          next_valid;
   logic [31:0]   next_instr;
   logic [63:0]   next_pc;

   function automatic logic [RW-1:0] ri_next(input logic [RW-1:0] p);
      return (p == RW'(MAX_INFLIGHT - 1)) ? '0 : p + RW'(1);
   endfunction

   always_comb begin
      beat_addr  = fetch_pc & BEAT_MASK;
      start_lane = LW'((fetch_pc >> 2) & 64'(IPB - 1));
      // Credit reserves a full beat for every read still outstanding, so the queue cannot overflow.
      issue      = !bus.set_pc_valid && (int'(inflight) < MAX_INFLIGHT)
                   && (int'(count) + IPB * (int'(inflight) + 1) <= QUEUE_DEPTH);
      resp       = bus.mem_rvalid;
      resp_addr  = ri_addr[ri_rd];
      resp_lane  = ri_lane[ri_rd];
      accept     = resp && !bus.set_pc_valid && (discard == '0);
      deq        = bus.out_valid && bus.out_ready && !bus.set_pc_valid;
      n_enq      = accept ? CW'(IPB - int'(resp_lane)) : '0;
      remaining  = count - CW'(deq);
      for (int j = 0; j < IPB; j++) begin
         enq_instr[j] = '0;
         enq_pc[j]    = '0;
         if (int'(resp_lane) + j < IPB) begin
            enq_instr[j] = bus.mem_rdata[32 * (int'(resp_lane) + j) +: 32];
            enq_pc[j]    = resp_addr + 64'(4 * (int'(resp_lane) + j));
         end
      end
      // The registered head is the next entry; when the queue drains it comes straight from the beat.
      next_valid = (remaining + n_enq) != '0;
      if (remaining == '0) begin
         next_instr = enq_instr[0];
         next_pc    = enq_pc[0];
      end else begin
         next_instr = q_instr[rd_ptr + QW'(deq)];
         next_pc    = q_pc[rd_ptr + QW'(deq)];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !bus.set_pc_valid) begin
         for (int j = 0; j < IPB; j++) begin
            if (j < int'(n_enq)) begin
               q_instr[wr_ptr + QW'(j)] <= enq_instr[j];
               q_pc[wr_ptr + QW'(j)]    <= enq_pc[j];
            end
         end
         if (issue) begin
            ri_addr[ri_wr] <= beat_addr;
            ri_lane[ri_wr] <= start_lane;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc      <= RESET_PC;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         ri_wr         <= '0;
         ri_rd         <= '0;
         inflight      <= '0;
         discard       <= '0;
         bus.mem_ren   <= 1'b0;
         bus.mem_raddr <= '0;
         bus.out_valid <= 1'b0;
         bus.out_instr <= '0;
         bus.out_pc    <= '0;
      end else if (bus.set_pc_valid) begin
         // Request info is kept so the stale responses still pop in order as they are dropped.
         fetch_pc      <= bus.set_pc & ~64'd3;
         count         <= '0;
         rd_ptr        <= wr_ptr;
         inflight      <= inflight - IW'(resp);
         discard       <= inflight - IW'(resp);
         if (resp)
            ri_rd <= ri_next(ri_rd);
         bus.mem_ren   <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.mem_ren <= issue;
         if (issue) begin
            bus.mem_raddr <= beat_addr;
            fetch_pc      <= beat_addr + 64'(BEAT_BYTES);
            ri_wr         <= ri_next(ri_wr);
         end
         if (resp) begin
            ri_rd <= ri_next(ri_rd);
            if (discard != '0)
               discard <= discard - IW'(1);
         end
         inflight      <= inflight + IW'(issue) - IW'(resp);
         wr_ptr        <= wr_ptr + QW'(n_enq);
         rd_ptr        <= rd_ptr + QW'(deq);
         count         <= remaining + n_enq;
         bus.out_valid <= next_valid;
         if (next_valid) begin
            bus.out_instr <= next_instr;
            bus.out_pc    <= next_pc;
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - vector table, memory model and pc scoreboard for fetch_queue_stage
module tb_fetch_queue_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_queue_stage_if #(.MEM_WIDTH(64))  bus ();
   fetch_queue_stage_if #(.MEM_WIDTH(128)) wbus ();

   fetch_queue_stage #(.MEM_WIDTH(64)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   fetch_queue_stage #(.MEM_WIDTH(128), .QUEUE_DEPTH(8), .MAX_INFLIGHT(2), .RESET_PC(64'h10)) wdut (
      .clk(clk), .rst(rst), .bus(wbus)
   );

   typedef struct {
      logic        ready;
      logic        ren;
      logic [63:0] raddr;
      logic        ov;
      logic [63:0] pc;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } req_t;

   vec_t        vec [9];
   req_t        pend [$];
   req_t        r;
   logic [63:0] exp_pc [$];
   logic [63:0] e;
   logic [63:0] hold_pc;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   int          n_out = 0;
   int          snap;
   int          max_count;
   logic        flag;
   logic        found;

   function automatic logic [31:0] instr_at(input logic [63:0] pc);
      if (pc == 64'h0) return 32'h11111111;
      if (pc == 64'h4) return 32'h22222222;
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic restart_sb(input logic [63:0] pc);
      exp_pc.delete();
      for (int i = 0; i < 256; i++)
         exp_pc.push_back(pc + 64'(4 * i));
   endtask

   task automatic mem_model();
      bus.mem_rvalid = 1'b0;
      if (rst) begin
         pend.delete();
         return;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
         r = pend.pop_front();
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = {instr_at(r.addr + 64'd4), instr_at(r.addr)};
      end
      if (bus.mem_ren)
         pend.push_back('{bus.mem_raddr, cyc + mem_lat});
   endtask

   task automatic score();
      if (!rst && !bus.set_pc_valid && bus.out_valid && bus.out_ready) begin
         n_out++;
         if (exp_pc.size() == 0) begin
            chk("sb_underflow", 64'(exp_pc.size()), 64'd1);
         end else begin
            e = exp_pc.pop_front();
            chk("sb_pc", bus.out_pc, e);
            chk("sb_instr", 64'(bus.out_instr), 64'(instr_at(e)));
         end
      end
   endtask

   task automatic step();
      mem_model();
      score();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ren"},   64'(bus.mem_ren), 64'd0);
      chk({tag, "_raddr"}, bus.mem_raddr, 64'd0);
      chk({tag, "_ov"},    64'(bus.out_valid), 64'd0);
      chk({tag, "_instr"}, 64'(bus.out_instr), 64'd0);
      chk({tag, "_pc"},    bus.out_pc, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec[0] = '{1'b1, 1'b1, 64'h00, 1'b0, 64'h00};
      vec[1] = '{1'b1, 1'b1, 64'h08, 1'b0, 64'h00};
      vec[2] = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h00};
      vec[3] = '{1'b0, 1'b1, 64'h10, 1'b1, 64'h04};
      vec[4] = '{1'b1, 1'b1, 64'h18, 1'b1, 64'h04};
      vec[5] = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h08};
      vec[6] = '{1'b1, 1'b1, 64'h20, 1'b1, 64'h0C};
      vec[7] = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h10};
      vec[8] = '{1'b1, 1'b1, 64'h28, 1'b1, 64'h14};

      rst = 1'b1;
      bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
      bus.set_pc_valid = 1'b0; bus.set_pc = '0; bus.out_ready = 1'b0;
      wbus.mem_rvalid = 1'b0; wbus.mem_rdata = '0;
      wbus.set_pc_valid = 1'b0; wbus.set_pc = '0; wbus.out_ready = 1'b0;
      @(negedge clk);
      repeat (3) step();
      chk_reset_outputs("reset");

      // Basic fetch, 1-cycle memory, one back-pressure cycle inside the table.
      rst = 1'b0;
      restart_sb(64'h0);
      step();
      for (int t = 0; t < 9; t++) begin
         chk($sformatf("vec%0d_ren", t), 64'(bus.mem_ren), 64'(vec[t].ren));
         if (vec[t].ren)
            chk($sformatf("vec%0d_raddr", t), bus.mem_raddr, vec[t].raddr);
         chk($sformatf("vec%0d_ov", t), 64'(bus.out_valid), 64'(vec[t].ov));
         if (vec[t].ov) begin
            chk($sformatf("vec%0d_pc", t), bus.out_pc, vec[t].pc);
            chk($sformatf("vec%0d_instr", t), 64'(bus.out_instr), 64'(instr_at(vec[t].pc)));
         end
         bus.out_ready = vec[t].ready;
         step();
      end

      // Back-pressure for 20 cycles.
      hold_pc = bus.out_pc;
      bus.out_ready = 1'b0;
      max_count = 0;
      flag = 1'b0;
      found = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (int'(dut.count) > max_count) max_count = int'(dut.count);
         if (i >= 10 && bus.mem_ren) flag = 1'b1;
         if (!bus.out_valid || bus.out_pc != hold_pc) found = 1'b0;
      end
      chk("bp_max_count", 64'(max_count), 64'd8);
      chk("bp_ren_idle", 64'(flag), 64'd0);
      chk("bp_head_stable", 64'(found), 64'd1);
      snap = n_out;
      bus.out_ready = 1'b1;
      repeat (30) step();
      chk("bp_resume_progress", 64'(n_out - snap >= 20), 64'd1);

      // Redirect to a misaligned target with two reads outstanding, 3-cycle memory.
      mem_lat = 3;
      repeat (10) step();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (pend.size() == 2) found = 1'b1;
         else step();
      end
      chk("redir_two_inflight", 64'(found), 64'd1);
      bus.set_pc_valid = 1'b1;
      bus.set_pc = 64'h106;
      restart_sb(64'h104);
      step();
      bus.set_pc_valid = 1'b0;
      chk("redir_discard", 64'(dut.discard), 64'(pend.size()));
      chk("redir_ov_low", 64'(bus.out_valid), 64'd0);
      chk("redir_ren_low", 64'(bus.mem_ren), 64'd0);
      snap = n_out;
      repeat (30) step();
      chk("redir_progress", 64'(n_out - snap >= 10), 64'd1);

      // Redirect coinciding with a response and a consumer handshake.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (pend.size() > 0 && pend[0].due == cyc && bus.out_valid) found = 1'b1;
         else step();
      end
      chk("simul_setup", 64'(found), 64'd1);
      bus.set_pc_valid = 1'b1;
      bus.set_pc = 64'h200;
      restart_sb(64'h200);
      step();
      bus.set_pc_valid = 1'b0;
      chk("simul_discard", 64'(dut.discard), 64'(pend.size()));
      chk("simul_ov_low", 64'(bus.out_valid), 64'd0);
      snap = n_out;
      repeat (30) step();
      chk("simul_progress", 64'(n_out - snap >= 10), 64'd1);

      // Reset in the middle of a partly filled queue.
      bus.out_ready = 1'b0;
      repeat (6) step();
      chk("mid_fill", 64'(dut.count >= 4'd2), 64'd1);
      rst = 1'b1;
      step();
      chk_reset_outputs("mid_reset");
      rst = 1'b0;
      restart_sb(64'h0);
      mem_lat = 1;
      step();
      chk("restart_ren", 64'(bus.mem_ren), 64'd1);
      chk("restart_raddr", bus.mem_raddr, 64'h0);
      bus.out_ready = 1'b1;
      snap = n_out;
      repeat (20) step();
      chk("restart_progress", 64'(n_out - snap >= 10), 64'd1);

      // 128-bit beats: one response fills four queue entries.
      bus.out_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      restart_sb(64'h0);
      step();
      chk("w_ren", 64'(wbus.mem_ren), 64'd1);
      chk("w_raddr", wbus.mem_raddr, 64'h10);
      step();
      wbus.mem_rvalid = 1'b1;
      wbus.mem_rdata = {instr_at(64'h1C), instr_at(64'h18), instr_at(64'h14), instr_at(64'h10)};
      step();
      wbus.mem_rvalid = 1'b0;
      chk("w_count", 64'(wdut.count), 64'd4);
      wbus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("w_ov%0d", k), 64'(wbus.out_valid), 64'd1);
         chk($sformatf("w_pc%0d", k), wbus.out_pc, 64'h10 + 64'(4 * k));
         chk($sformatf("w_instr%0d", k), 64'(wbus.out_instr), 64'(instr_at(64'h10 + 64'(4 * k))));
         step();
      end
      chk("w_drained", 64'(wbus.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
